// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit of the 5-stage MIPS pipeline.
// Takes the memory op latched in EX/MEM, runs a request/ack handshake on
// the data bus, formats load data (byte/half lane select plus sign or zero
// extension) and presents the write-back triple to MEM/WB. stallreq holds
// the pipeline while an access is outstanding.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   stall[5:0]            stall vector; only stall[4] (MEM stage) is used
//   i_we, i_write_addr,   write-back request from EX/MEM
//   i_write_data
//   i_mem_op              0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW,
//                         6 SB, 7 SH, 8 SW, 9-15 none
//   i_mem_addr            effective address
//   i_store_data          store operand
//   bus_*                 data-bus master (registered request side)
//   mem_we, mem_write_addr,
//   mem_write_instr       write-back triple to MEM/WB
//   stallreq              stall request to the controller
//   align_err             misaligned access, no bus cycle issued
module mem_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              i_we,
    input  logic [4:0]        i_write_addr,
    input  logic [DATA_W-1:0] i_write_data,
    input  logic [3:0]        i_mem_op,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_store_data,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_sel,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              mem_we,
    output logic [4:0]        mem_write_addr,
    output logic [DATA_W-1:0] mem_write_instr,
    output logic              stallreq,
    output logic              align_err
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t            state_q, state_nxt;
    logic [DATA_W-1:0] load_data_q;

    logic is_load, is_store, is_byte, is_half, is_word, is_signed;
    logic is_mem, misaligned, start;
    logic [3:0]        sel_nxt;
    logic [DATA_W-1:0] wdata_nxt;

    // Only the MEM-stage bit of the stall vector matters here.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[3:0]};

    // Extract the addressed lane (big-endian: offset 0 is bits 31:24) and
    // extend it to a full word.
    function automatic logic [DATA_W-1:0] format_load(
        input logic              sgn,
        input logic              byte_op,
        input logic              half_op,
        input logic [1:0]        off,
        input logic [DATA_W-1:0] rdata
    );
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [DATA_W-1:0]  res;
        case (off)
            2'd0:    b = rdata[31:24];
            2'd1:    b = rdata[23:16];
            2'd2:    b = rdata[15:8];
            default: b = rdata[7:0];
        endcase
        h = off[1] ? rdata[15:0] : rdata[31:16];
        if (byte_op)
            res = {{24{sgn & b[7]}}, b};
        else if (half_op)
            res = {{16{sgn & h[15]}}, h};
        else
            res = rdata;
        return res;
    endfunction

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        is_signed = 1'b0;
        case (i_mem_op)
            4'd1: begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
            4'd2: begin is_load  = 1'b1; is_byte = 1'b1; end
            4'd3: begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
            4'd4: begin is_load  = 1'b1; is_half = 1'b1; end
            4'd5: begin is_load  = 1'b1; is_word = 1'b1; end
            4'd6: begin is_store = 1'b1; is_byte = 1'b1; end
            4'd7: begin is_store = 1'b1; is_half = 1'b1; end
            4'd8: begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    assign is_mem     = is_load | is_store;
    assign misaligned = (is_half & i_mem_addr[0]) | (is_word & (|i_mem_addr[1:0]));
    assign start      = is_mem & ~misaligned;

    always_comb begin
        if (is_byte)
            sel_nxt = 4'b1000 >> i_mem_addr[1:0];
        else if (is_half)
            sel_nxt = i_mem_addr[1] ? 4'b0011 : 4'b1100;
        else
            sel_nxt = 4'b1111;
    end

    always_comb begin
        if (is_byte)
            wdata_nxt = {4{i_store_data[7:0]}};
        else if (is_half)
            wdata_nxt = {2{i_store_data[15:0]}};
        else
            wdata_nxt = i_store_data;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (start)    state_nxt = BUS;
            BUS:     if (bus_ack)  state_nxt = DONE;
            DONE:    if (!stall[4]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus request side: fields captured once on IDLE->BUS and held until
    // the next access; only bus_req drops on the ack edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_sel   <= 4'b0000;
            bus_wdata <= '0;
        end else if (state_q == IDLE && start) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {i_mem_addr[ADDR_W-1:2], 2'b00};
            bus_sel   <= sel_nxt;
            bus_wdata <= wdata_nxt;
        end else if (state_q == BUS && bus_ack) begin
            bus_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            load_data_q <= '0;
        else if (state_q == BUS && bus_ack && is_load)
            load_data_q <= format_load(is_signed, is_byte, is_half,
                                       i_mem_addr[1:0], bus_rdata);
    end

    // Outputs are forced to zero while reset is held.
    always_comb begin
        mem_we          = 1'b0;
        mem_write_addr  = 5'd0;
        mem_write_instr = '0;
        stallreq        = 1'b0;
        align_err       = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    mem_write_addr = i_write_addr;
                    if (!is_mem) begin
                        mem_we          = i_we;
                        mem_write_instr = i_write_data;
                    end else if (misaligned) begin
                        align_err = 1'b1;
                    end else begin
                        stallreq = 1'b1;
                    end
                end
                BUS: begin
                    mem_write_addr = i_write_addr;
                    stallreq       = 1'b1;
                end
                DONE: begin
                    mem_write_addr = i_write_addr;
                    if (is_load) begin
                        mem_we          = i_we;
                        mem_write_instr = load_data_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        i_we;
    logic [4:0]  i_write_addr;
    logic [31:0] i_write_data;
    logic [3:0]  i_mem_op;
    logic [31:0] i_mem_addr;
    logic [31:0] i_store_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        mem_we;
    logic [4:0]  mem_write_addr;
    logic [31:0] mem_write_instr;
    logic        stallreq;
    logic        align_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .i_we(i_we), .i_write_addr(i_write_addr), .i_write_data(i_write_data),
        .i_mem_op(i_mem_op), .i_mem_addr(i_mem_addr), .i_store_data(i_store_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .mem_we(mem_we), .mem_write_addr(mem_write_addr),
        .mem_write_instr(mem_write_instr), .stallreq(stallreq), .align_err(align_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: access size in bytes, 0 for non-memory ops.
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [3:0] model_sel(input int size, input int off);
        logic [3:0] s = 4'b0000;
        for (int k = off; k < off + size; k++) s[3-k] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input int size, input logic [31:0] v);
        longint mask = (64'd1 << (8 * size)) - 1;
        longint w = 0;
        for (int i = 0; i < 4 / size; i++) w = w | ((longint'(v) & mask) << (8 * size * i));
        return w[31:0];
    endfunction

    function automatic logic [31:0] model_load(input int size, input int off, input bit sgn,
                                               input logic [31:0] rdata);
        longint v = (longint'(rdata) >> (8 * (4 - off - size))) & ((64'd1 << (8 * size)) - 1);
        if (sgn && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
        return v[31:0];
    endfunction

    // Runs one EX/MEM op. Entered and left at posedge+1 with the DUT in IDLE.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic we,
                          input logic [4:0] waddr, input logic [31:0] wdata,
                          input logic [31:0] sdata, input logic [31:0] rdata,
                          input int waits, input int hold);
        int  size  = op_size(op);
        int  off   = int'(addr[1:0]);
        bit  store = (op >= 4'd6 && op <= 4'd8);
        bit  sgn   = (op == 4'd1 || op == 4'd3);
        int  stall_cnt = 0;
        logic [31:0] exp_load;
        i_mem_op = op; i_mem_addr = addr; i_we = we; i_write_addr = waddr;
        i_write_data = wdata; i_store_data = sdata;
        @(negedge clk);
        if (size == 0) begin
            check("pass_we", {31'd0, mem_we}, {31'd0, we});
            check("pass_addr", {27'd0, mem_write_addr}, {27'd0, waddr});
            check("pass_data", mem_write_instr, wdata);
            check("pass_stall", {31'd0, stallreq}, 32'd0);
            @(posedge clk); #1;
        end else if ((addr % size) != 0) begin
            check("mis_align_err", {31'd0, align_err}, 32'd1);
            check("mis_stall", {31'd0, stallreq}, 32'd0);
            check("mis_we", {31'd0, mem_we}, 32'd0);
            @(posedge clk); #1;
            check("mis_bus_req", {31'd0, bus_req}, 32'd0);
        end else begin
            exp_load = model_load(size, off, sgn, rdata);
            check("idle_we", {31'd0, mem_we}, 32'd0);
            check("idle_req", {31'd0, bus_req}, 32'd0);
            if (stallreq) stall_cnt++;
            @(posedge clk); #1;
            for (int w = 0; w <= waits; w++) begin
                @(negedge clk);
                check("bus_req", {31'd0, bus_req}, 32'd1);
                check("bus_addr", bus_addr, {addr[31:2], 2'b00});
                check("bus_sel", {28'd0, bus_sel}, {28'd0, model_sel(size, off)});
                check("bus_we", {31'd0, bus_we}, {31'd0, store});
                if (store) check("bus_wdata", bus_wdata, model_wdata(size, sdata));
                check("bus_mem_we", {31'd0, mem_we}, 32'd0);
                if (stallreq) stall_cnt++;
                if (w == waits) begin
                    bus_ack = 1'b1; bus_rdata = rdata;
                    stall[4] = (hold > 0);
                end
                @(posedge clk); #1;
                bus_ack = 1'b0; bus_rdata = $urandom;
            end
            for (int h = 0; h <= hold; h++) begin
                @(negedge clk);
                check("done_req", {31'd0, bus_req}, 32'd0);
                check("done_we", {31'd0, mem_we}, {31'd0, (!store) & we});
                check("done_addr", {27'd0, mem_write_addr}, {27'd0, waddr});
                if (!store) check("done_data", mem_write_instr, exp_load);
                if (stallreq) stall_cnt++;
                @(posedge clk); #1;
                stall[4] = (h + 1 < hold);
            end
            check("stall_cycles", stall_cnt, waits + 2);
        end
        i_mem_op = 4'd0;
    endtask

    initial begin
        rst = 1'b1; stall = 6'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        i_we = 1'b1; i_write_addr = 5'd5; i_write_data = 32'h12345678;
        i_mem_op = 4'd0; i_mem_addr = 32'd0; i_store_data = 32'd0;
        #2;
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_waddr", {27'd0, mem_write_addr}, 32'd0);
        check("rst_data", mem_write_instr, 32'd0);
        check("rst_stall", {31'd0, stallreq}, 32'd0);
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_bus_sel", {28'd0, bus_sel}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(4'd0, 32'h0, 1'b1, 5'd5, 32'h12345678, 32'h0, 32'h0, 0, 0);
        run_op(4'd1, 32'h101, 1'b1, 5'd7, 32'h0, 32'h0, 32'h80FF7F01, 2, 0);
        run_op(4'd2, 32'h101, 1'b1, 5'd7, 32'h0, 32'h0, 32'h80FF7F01, 2, 0);
        run_op(4'd7, 32'h202, 1'b1, 5'd9, 32'h0, 32'hAAAA1234, 32'h0, 1, 0);
        run_op(4'd5, 32'h3, 1'b1, 5'd3, 32'h0, 32'h0, 32'h0, 0, 0);
        run_op(4'd5, 32'h400, 1'b1, 5'd4, 32'h0, 32'h0, 32'hCAFEF00D, 0, 2);
        run_op(4'd3, 32'h402, 1'b1, 5'd4, 32'h0, 32'h0, 32'h1234F00D, 0, 0);

        // Reset while the bus access is outstanding.
        i_mem_op = 4'd5; i_mem_addr = 32'h500; i_we = 1'b1; i_write_addr = 5'd2;
        @(posedge clk); #1;
        check("midbus_req", {31'd0, bus_req}, 32'd1);
        rst = 1'b1; #1;
        check("midbus_rst_req", {31'd0, bus_req}, 32'd0);
        check("midbus_rst_stall", {31'd0, stallreq}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; i_mem_op = 4'd0; i_we = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("late_ack_we", {31'd0, mem_we}, 32'd0);
        check("late_ack_req", {31'd0, bus_req}, 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        check("late_ack_req2", {31'd0, bus_req}, 32'd0);
        run_op(4'd0, 32'h0, 1'b1, 5'd11, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [3:0]  op;
            logic [31:0] a;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (op_size(op) == 2) a[0] = 1'b0;
                if (op_size(op) == 4) a[1:0] = 2'b00;
            end
            run_op(op, a, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                   $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
